izh_spike_synapse: RTL

- Receiving end of the neuron spike interface. Converts a presynaptic spike train, one-cycle `spike` pulses from an Izhikevich neuron core, into the signed 20-bit Q4.16 input current `I` that drives a downstream neuron core.
- Implements a first-order exponentially decaying synaptic current with a refractory dead-time.
- Measures the inter-spike interval (ISI) and offers each measurement to a monitor over a valid/ready handshake.

---
 rtl/izh_spike_synapse_pkg.sv | 21 ++
 rtl/izh_spike_synapse_sat_add_q416.sv | 27 ++
 rtl/izh_spike_synapse.sv | 122 ++++++++++++
 3 files changed

// File: rtl/izh_spike_synapse_pkg.sv
// Shared Q4.16 constants and types for the Izhikevich neuron core and its spike synapse.
package izh_spike_synapse_pkg;

    localparam int Q_W    = 20;
    localparam int Q_FRAC = 16;

    localparam logic signed [Q_W-1:0] SAT_MAX = 20'sh7_FFFF;
    localparam logic signed [Q_W-1:0] SAT_MIN = 20'sh8_0000;
    localparam logic signed [Q_W-1:0] Q_ONE   = 20'sh1_0000;

    // Neuron-core coefficients in Q4.16
    localparam logic signed [Q_W-1:0] NEURON_K_0P04 = 20'sh0_0A3D;
    localparam logic signed [Q_W-1:0] NEURON_K_1P4  = 20'sh1_6666;
    localparam logic signed [Q_W-1:0] NEURON_K_5P0  = 20'sh5_0000;

    typedef enum logic {
        ISI_NO_REF   = 1'b0,
        ISI_COUNTING = 1'b1
    } isi_state_e;

endpackage

// File: rtl/izh_spike_synapse_sat_add_q416.sv
// Signed (W+2)-bit addition saturated to the W-bit Q4.16 range; shared with the neuron core.
module sat_add_q416 #(
    parameter int W = 20
) (
    input  logic signed [W+1:0] a_i,
    input  logic signed [W+1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] sum_full;

    // NOTE: every path assigns sum_o, so this block stays purely combinational (no latch).
    always_comb begin
        sum_full = a_i + b_i;
        if (sum_full > MAX_EXT) begin
            sum_o = MAX_EXT[W-1:0];
        end else if (sum_full < MIN_EXT) begin
            sum_o = MIN_EXT[W-1:0];
        end else begin
            sum_o = sum_full[W-1:0];
        end
    end

endmodule

// File: rtl/izh_spike_synapse.sv
// Spike-to-current synapse: decaying Q4.16 current with refractory dead-time and ISI measurement.
module izh_spike_synapse
    import izh_spike_synapse_pkg::*;
#(
    parameter int W         = 20,
    parameter int TAU_SHIFT = 3,
    parameter int REFRAC    = 2,
    parameter int ISI_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                spike_in,
    input  logic signed [W-1:0] weight,
    output logic signed [W-1:0] i_out,
    output logic [ISI_W-1:0]    isi_out,
    output logic                isi_valid,
    input  logic                isi_ready,
    output logic                isi_ovf,
    output logic                isi_drop
);

    localparam int               RW          = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RW-1:0]    REFRAC_LOAD = RW'(REFRAC);
    localparam logic [ISI_W-1:0] ISI_MAX     = '1;

    logic [RW-1:0]       refrac_q;
    logic signed [W-1:0] i_q;
    logic signed [W-1:0] i_d;
    isi_state_e          state_q;
    logic [ISI_W-1:0]    cnt_q;
    logic [ISI_W-1:0]    isi_q;
    logic                valid_q;
    logic                ovf_q;
    logic                drop_q;

    logic                acc;
    logic signed [W+1:0] i_ext;
    logic signed [W+1:0] w_ext;
    logic signed [W+1:0] decayed;
    logic signed [W+1:0] add_term;
    logic [ISI_W-1:0]    capture;
    logic                capture_sat;
    logic                slot_free;

    always_comb begin
        acc         = en & spike_in & (refrac_q == '0);
        i_ext       = {{2{i_q[W-1]}}, i_q};
        w_ext       = {{2{weight[W-1]}}, weight};
        // Arithmetic shift floors, so negative currents decay all the way to zero
        decayed     = i_ext - (i_ext >>> TAU_SHIFT);
        add_term    = acc ? w_ext : '0;
        capture_sat = (cnt_q == ISI_MAX);
        capture     = capture_sat ? ISI_MAX : cnt_q + 1'b1;
        slot_free   = ~valid_q | isi_ready;
    end

    sat_add_q416 #(.W(W)) u_sat (
        .a_i   (decayed),
        .b_i   (add_term),
        .sum_o (i_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q      <= '0;
            refrac_q <= '0;
            state_q  <= ISI_NO_REF;
            cnt_q    <= '0;
            isi_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            if (en) begin
                i_q <= i_d;
            end

            if (acc) begin
                refrac_q <= REFRAC_LOAD;
            end else if (en && refrac_q != '0) begin
                refrac_q <= refrac_q - 1'b1;
            end

            // NOTE: a later non-blocking assignment in this block wins, so a same-cycle publish keeps valid high.
            if (valid_q && isi_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ISI_NO_REF: begin
                    if (acc) begin
                        state_q <= ISI_COUNTING;
                        cnt_q   <= '0;
                    end
                end
                ISI_COUNTING: begin
                    if (acc) begin
                        cnt_q <= '0;
                        if (slot_free) begin
                            isi_q   <= capture;
                            ovf_q   <= capture_sat;
                            valid_q <= 1'b1;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (en && cnt_q != ISI_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ISI_NO_REF;
            endcase
        end
    end

    assign i_out     = i_q;
    assign isi_out   = isi_q;
    assign isi_valid = valid_q;
    assign isi_ovf   = ovf_q;
    assign isi_drop  = drop_q;

endmodule
